// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Stall-able pipeline register with a valid/ready handshake and a 2-entry skid
// buffer. The main register always drives out_data. The skid register catches
// the beat accepted in the cycle downstream stops taking data, which lets
// in_ready come from a register and still sustain one transfer per cycle.
// A flush drops every held entry and loads the bubble value NOP_VAL into the
// main register. A global stall freezes the whole block.
//
// Parameters:
//   WIDTH      payload width in bits
//   RESET_VAL  value loaded into both data registers on reset
//   NOP_VAL    bubble value loaded into the main register on flush
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   stall      global hold; no transfer on either side while high
//   flush      drop all entries and present the bubble value
//   in_valid   upstream payload valid
//   in_ready   block can take in_data this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts this cycle
//   out_data   payload (main register)
//   occupancy  entries held: 0, 1 or 2
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] NOP_VAL   = WIDTH'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;

    // Status flags kept as registers, written alongside the state so that
    // out_valid, occupancy and the state term of in_ready come straight from
    // flops.
    logic             valid_q;
    logic             full_q;
    logic [1:0]       occ_q;

    logic             in_fire_s;
    logic             out_fire_s;

    // Only stall and flush reach in_ready combinationally.
    assign in_ready   = ~full_q & ~stall & ~flush;
    assign out_valid  = valid_q;
    assign out_data   = main_q;
    assign occupancy  = occ_q;

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = valid_q & out_ready & ~stall;

    // Occupancy encoding of a state.
    function automatic logic [1:0] occ_of(input state_e st);
        logic [1:0] occ;
        case (st)
            ST_EMPTY: occ = 2'd0;
            ST_BUSY:  occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

    // Next-state and datapath selection; flush beats stall beats handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // The skid contents simply become stale; only the state matters.
            state_d = ST_EMPTY;
            main_d  = NOP_VAL;
        end else if (stall) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d = ST_BUSY;
                        main_d  = in_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire_s && out_fire_s) begin
                        state_d = ST_BUSY;
                        main_d  = in_data;
                    end else if (in_fire_s) begin
                        // Downstream stalled: park the new beat behind main.
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (out_fire_s) begin
                        // main keeps the consumed value while the block is empty.
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        state_d = ST_BUSY;
                        main_d  = skid_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State, data and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            occ_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= (state_d != ST_EMPTY);
            full_q  <= (state_d == ST_FULL);
            occ_q   <= occ_of(state_d);
        end
    end

endmodule
